// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared constants for the two-requester RAM arbiter
package ram_arbiter_pkg;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  function automatic int depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// rtl/ram_arbiter_rr_arb2.sv - two-way round-robin grant with registered tie-break pointer
module rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  // ptr names the requester that wins when both ask in the same cycle
  logic ptr;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      if (i_req[REQ_A] && (!i_req[REQ_B] || ptr == REQ_A)) begin
        o_gnt[REQ_A] = 1'b1;
      end else if (i_req[REQ_B]) begin
        o_gnt[REQ_B] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr <= REQ_A;
    end else if (o_gnt[REQ_A]) begin
      ptr <= REQ_B;
    end else if (o_gnt[REQ_B]) begin
      ptr <= REQ_A;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - clears a single-port RAM, then round-robins accesses from two clients
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  output logic                  o_busy,
  output logic                  o_init_done,
  input  logic                  i_a_req,
  input  logic                  i_a_we,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  input  logic [DATA_WIDTH-1:0] i_a_wdata,
  output logic                  o_a_gnt,
  output logic                  o_a_rvalid,
  output logic [DATA_WIDTH-1:0] o_a_rdata,
  input  logic                  i_b_req,
  input  logic                  i_b_we,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  input  logic [DATA_WIDTH-1:0] i_b_wdata,
  output logic                  o_b_gnt,
  output logic                  o_b_rvalid,
  output logic [DATA_WIDTH-1:0] o_b_rdata,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam int DEPTH = depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  a_rv;
  logic                  b_rv;
  logic [1:0]            gnt;
  logic                  arb_en;

  // the clear-request cycle itself leaves the memory idle
  assign arb_en = (state == ST_RUN) && !i_clear;

  rr_arb2 u_rr_arb2 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   ({i_b_req, i_a_req}),
    .i_en    (arb_en),
    .o_gnt   (gnt)
  );

  assign o_a_gnt     = gnt[REQ_A];
  assign o_b_gnt     = gnt[REQ_B];
  assign o_busy      = (state == ST_INIT);
  assign o_init_done = (state == ST_RUN);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
      a_rv    <= 1'b0;
      b_rv    <= 1'b0;
    end else begin
      // read flags follow grants regardless of state so a read issued
      // just before a clear still returns its data
      a_rv <= gnt[REQ_A] && !i_a_we;
      b_rv <= gnt[REQ_B] && !i_b_we;
      if (state == ST_INIT) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == LAST_ADDR) begin
          state <= ST_RUN;
        end
      end else if (i_clear) begin
        state   <= ST_INIT;
        clr_cnt <= '0;
      end
    end
  end

  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (state == ST_INIT) begin
      o_mem_we   = 1'b1;
      o_mem_addr = clr_cnt;
    end else if (gnt[REQ_A]) begin
      o_mem_we    = i_a_we;
      o_mem_addr  = i_a_addr;
      o_mem_wdata = i_a_wdata;
    end else if (gnt[REQ_B]) begin
      o_mem_we    = i_b_we;
      o_mem_addr  = i_b_addr;
      o_mem_wdata = i_b_wdata;
    end
  end

  assign o_a_rvalid = a_rv;
  assign o_b_rvalid = b_rv;
  assign o_a_rdata  = a_rv ? i_mem_rdata : '0;
  assign o_b_rdata  = b_rv ? i_mem_rdata : '0;

endmodule
